mac_row_sequencer: RTL

Tick-driven address and control sequencer for the complex fixed-point MAC datapath. It computes a matrix-vector product one row at a time. Memory 1 holds a complex matrix and memory 2 holds a complex vector, each stored with the real part at even addresses and the imaginary part at odd addresses on dual-port RAMs. For every row the block drives the port addresses, clears the accumulator, and gates accumulation with `ena`. It raises a per-row result strobe and holds a completion flag at the end. It replaces hand-driven address stimulus between the slow-clock divider and the MAC top.

---
 rtl/mac_seq_pkg.sv | 25 ++
 rtl/tick_delay_line.sv | 38 +++
 rtl/mac_row_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared state encoding, counter-width helper and real/imaginary address
// interleave rule for the MAC row sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Width of a counter/index that must hold values 0..n-1 (never zero bits).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Complex element idx lives at two consecutive RAM words: real first.
    function automatic int re_addr(input int idx);
        return 2 * idx;
    endfunction

    function automatic int im_addr(input int idx);
        return 2 * idx + 1;
    endfunction

endpackage

// File: rtl/tick_delay_line.sv
// LAT-deep shift register that only advances on the slow tick; used to turn
// the issue-valid bit into the accumulator enable.
module tick_delay_line #(
    parameter int LAT = 2
) (
    input  logic clk_seq,
    input  logic rst_seq,
    input  logic tick_seq,
    input  logic flush_seq,
    input  logic din_seq,
    output logic dout_seq
);

    logic [LAT-1:0] sr_q;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk_seq) begin
                if (!rst_seq || flush_seq) begin
                    sr_q <= '0;
                end else if (tick_seq) begin
                    sr_q <= din_seq;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk_seq) begin
                if (!rst_seq || flush_seq) begin
                    sr_q <= '0;
                end else if (tick_seq) begin
                    sr_q <= {sr_q[LAT-2:0], din_seq};
                end
            end
        end
    endgenerate

    assign dout_seq = sr_q[LAT-1];

endmodule

// File: rtl/mac_row_sequencer.sv
// Tick-driven row-at-a-time address/control sequencer for the complex MAC.
//   state    | meaning
//   ST_IDLE  | waiting for a start (pending start kept until the next tick)
//   ST_ISSUE | driving element k of row r, one element per tick
//   ST_DRAIN | LAT ticks for the last product to reach the accumulator
module mac_row_sequencer
    import mac_seq_pkg::*;
#(
    parameter int NDIR = 4,
    parameter int NCOL = 2,
    parameter int NROW = 4,
    parameter int LAT  = 2
) (
    input  logic                        clk_seq,
    input  logic                        rst_seq,
    input  logic                        tick_seq,
    input  logic                        start_seq,
    input  logic                        abort_seq,
    output logic [NDIR-1:0]             addr_am1_seq,
    output logic [NDIR-1:0]             addr_bm1_seq,
    output logic [NDIR-1:0]             addr_am2_seq,
    output logic [NDIR-1:0]             addr_bm2_seq,
    output logic                        clr_seq,
    output logic                        ena_seq,
    output logic                        valid_seq,
    output logic [idx_width(NROW)-1:0]  row_seq,
    output logic                        busy_seq,
    output logic                        flag_seq
);

    localparam int RW = idx_width(NROW);
    localparam int KW = idx_width(NCOL);
    localparam int DW = idx_width(LAT);

    seq_state_t      state_q, state_d;
    logic            pend_q, pend_d;
    logic [RW-1:0]   r_q, r_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   d_q, d_d;
    logic [NDIR-1:0] am1_q, am1_d, bm1_q, bm1_d, am2_q, am2_d, bm2_q, bm2_d;
    logic            clr_q, clr_d, valid_q, valid_d, busy_q, busy_d, flag_q, flag_d;
    logic [RW-1:0]   row_q, row_d;
    logic            load_addr;
    logic            issue_vld;

    always_ff @(posedge clk_seq) begin
        if (!rst_seq) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            r_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            am1_q   <= '0;
            bm1_q   <= '0;
            am2_q   <= '0;
            bm2_q   <= '0;
            clr_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            r_q     <= r_d;
            k_q     <= k_d;
            d_q     <= d_d;
            am1_q   <= am1_d;
            bm1_q   <= bm1_d;
            am2_q   <= am2_d;
            bm2_q   <= bm2_d;
            clr_q   <= clr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        r_d       = r_q;
        k_d       = k_q;
        d_d       = d_q;
        clr_d     = clr_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        flag_d    = flag_q;
        row_d     = row_q;
        load_addr = 1'b0;

        if (abort_seq) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            clr_d   = 1'b0;
            busy_d  = 1'b0;
            flag_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick_seq && (start_seq || pend_q)) begin
                        state_d   = ST_ISSUE;
                        pend_d    = 1'b0;
                        r_d       = '0;
                        k_d       = '0;
                        clr_d     = 1'b1;
                        busy_d    = 1'b1;
                        flag_d    = 1'b0;
                        load_addr = 1'b1;
                    end else if (start_seq) begin
                        pend_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (tick_seq) begin
                        clr_d = 1'b0;
                        if (k_q == KW'(NCOL - 1)) begin
                            state_d = ST_DRAIN;
                            d_d     = DW'(LAT - 1);
                        end else begin
                            k_d       = k_q + KW'(1);
                            load_addr = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tick_seq) begin
                        if (d_q == '0) begin
                            valid_d = 1'b1;
                            row_d   = r_q;
                            if (r_q == RW'(NROW - 1)) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                flag_d  = 1'b1;
                            end else begin
                                // Next row's first element and clear share the valid edge.
                                state_d   = ST_ISSUE;
                                r_d       = r_q + RW'(1);
                                k_d       = '0;
                                clr_d     = 1'b1;
                                load_addr = 1'b1;
                            end
                        end else begin
                            d_d = d_q - DW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        am1_d = am1_q;
        bm1_d = bm1_q;
        am2_d = am2_q;
        bm2_d = bm2_q;
        if (load_addr) begin
            am1_d = NDIR'(re_addr(int'(r_d) * NCOL + int'(k_d)));
            bm1_d = NDIR'(im_addr(int'(r_d) * NCOL + int'(k_d)));
            am2_d = NDIR'(re_addr(int'(k_d)));
            bm2_d = NDIR'(im_addr(int'(k_d)));
        end
    end

    assign issue_vld = (state_q == ST_ISSUE);

    tick_delay_line #(.LAT(LAT)) u_dly (
        .clk_seq   (clk_seq),
        .rst_seq   (rst_seq),
        .tick_seq  (tick_seq),
        .flush_seq (abort_seq),
        .din_seq   (issue_vld),
        .dout_seq  (ena_seq)
    );

    assign addr_am1_seq = am1_q;
    assign addr_bm1_seq = bm1_q;
    assign addr_am2_seq = am2_q;
    assign addr_bm2_seq = bm2_q;
    assign clr_seq      = clr_q;
    assign valid_seq    = valid_q;
    assign row_seq      = row_q;
    assign busy_seq     = busy_q;
    assign flag_seq     = flag_q;

endmodule
